// File: rtl/serial_adder.sv
// Bit-serial adder: half adder + half adder + OR + carry flop, one operand bit per clock.
// Latency: WIDTH edges from the accepting edge to result_valid; min initiation interval WIDTH+2.
// Backpressure: start_ready only in IDLE; result_ready low holds DONE with outputs frozen.

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;

    logic p_bit, g_bit, s_bit, t_bit, c_next;

    half_adder u_ha0 (.a(a_sr[0]), .b(b_sr[0]), .s(p_bit), .c(g_bit));
    half_adder u_ha1 (.a(p_bit),   .b(carry),   .s(s_bit), .c(t_bit));
    assign c_next = g_bit | t_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            res   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_sr  <= a_in;
                        b_sr  <= b_in;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Sum bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    res   <= {s_bit, res[WIDTH-1:1]};
                    carry <= c_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign start_ready  = (state == IDLE);
    assign busy         = (state == RUN);
    assign result_valid = (state == DONE);

    // Partial sums and the running carry stay hidden until the result is complete.
    assign sum_out = result_valid ? res : '0;
    assign cout    = result_valid & carry;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: vector table and directed corner cases at WIDTH=8, then a
// scoreboarded random regression at WIDTH=8 and WIDTH=16 with result_ready stalls.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       sv8, sr8, cin8, rv8, rr8, co8, busy8;
    logic [7:0] a8, b8, s8;

    logic        sv16, sr16, cin16, rv16, rr16, co16, busy16;
    logic [15:0] a16, b16, s16;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .start_valid(sv8), .start_ready(sr8),
        .a_in(a8), .b_in(b8), .cin(cin8),
        .result_valid(rv8), .result_ready(rr8),
        .sum_out(s8), .cout(co8), .busy(busy8)
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .start_valid(sv16), .start_ready(sr16),
        .a_in(a16), .b_in(b16), .cin(cin16),
        .result_valid(rv16), .result_ready(rr16),
        .sum_out(s16), .cout(co16), .busy(busy16)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int ecnt  = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec_t;

    typedef struct {
        logic [32:0] exp;
        int          edge_n;
    } sb_t;

    sb_t  q8[$];
    sb_t  q16[$];
    logic mon_en = 1'b0;
    logic rnd_en = 1'b0;
    logic rv8_prev = 1'b0;
    logic rv16_prev = 1'b0;
    int   got8 = 0;
    int   got16 = 0;

    // Scoreboard: push on the handshake that will be accepted, pop on result handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sv8 && sr8)
                q8.push_back('{exp: 33'(a8) + 33'(b8) + 33'(cin8), edge_n: ecnt + 1});
            if (rv8 && !rv8_prev) begin
                if (q8.size() == 0) chk("unexpected_valid8", 1, 0);
                else                chk("latency8", 64'(ecnt - q8[0].edge_n), 8);
            end
            if (rv8 && rr8) begin
                if (q8.size() == 0) chk("extra_result8", 1, 0);
                else begin
                    chk("rand_sum8", 64'({co8, s8}), 64'(q8[0].exp));
                    void'(q8.pop_front());
                    got8 <= got8 + 1;
                end
            end
            if (sv16 && sr16)
                q16.push_back('{exp: 33'(a16) + 33'(b16) + 33'(cin16), edge_n: ecnt + 1});
            if (rv16 && !rv16_prev) begin
                if (q16.size() == 0) chk("unexpected_valid16", 1, 0);
                else                 chk("latency16", 64'(ecnt - q16[0].edge_n), 16);
            end
            if (rv16 && rr16) begin
                if (q16.size() == 0) chk("extra_result16", 1, 0);
                else begin
                    chk("rand_sum16", 64'({co16, s16}), 64'(q16[0].exp));
                    void'(q16.pop_front());
                    got16 <= got16 + 1;
                end
            end
        end
        rv8_prev  <= rv8;
        rv16_prev <= rv16;
    end

    always @(posedge clk) begin
        if (rnd_en) begin
            #1;
            rr8  = ($urandom_range(0, 2) != 0);
            rr16 = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int cnt = 0;
        while (!sr8 && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (cnt >= 50) chk("start8_timeout", 64'(cnt), 0);
        sv8 = 1'b1; a8 = a; b8 = b; cin8 = c;
        @(posedge clk); #1;
        sv8 = 1'b0;
    endtask

    task automatic wait_rv8(output int lat);
        lat = 0;
        while (!rv8 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic accept8();
        rr8 = 1'b1;
        @(posedge clk); #1;
        rr8 = 1'b0;
    endtask

    task automatic drv8();
        for (int i = 0; i < 1000; i++) begin
            int cnt = 0;
            while (!sr8 && cnt < 500) begin
                @(posedge clk); #1;
                cnt++;
            end
            if (cnt >= 500) begin
                chk("drv8_timeout", 64'(cnt), 0);
                break;
            end
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom_range(0, 1));
            sv8 = 1'b1;
            @(posedge clk); #1;
            sv8 = 1'b0;
        end
    endtask

    task automatic drv16();
        for (int i = 0; i < 1000; i++) begin
            int cnt = 0;
            while (!sr16 && cnt < 500) begin
                @(posedge clk); #1;
                cnt++;
            end
            if (cnt >= 500) begin
                chk("drv16_timeout", 64'(cnt), 0);
                break;
            end
            a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom_range(0, 1));
            sv16 = 1'b1;
            @(posedge clk); #1;
            sv16 = 1'b0;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vt[9];
        int   lat;

        vt[0] = '{a: 8'h35, b: 8'h1C, cin: 1'b0, s: 8'h51, co: 1'b0};
        vt[1] = '{a: 8'hFF, b: 8'h00, cin: 1'b1, s: 8'h00, co: 1'b1};
        vt[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, co: 1'b1};
        vt[3] = '{a: 8'h01, b: 8'h01, cin: 1'b0, s: 8'h02, co: 1'b0};
        vt[4] = '{a: 8'h00, b: 8'h00, cin: 1'b0, s: 8'h00, co: 1'b0};
        vt[5] = '{a: 8'h80, b: 8'h80, cin: 1'b0, s: 8'h00, co: 1'b1};
        vt[6] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, s: 8'h80, co: 1'b0};
        vt[7] = '{a: 8'hAA, b: 8'h55, cin: 1'b1, s: 8'h00, co: 1'b1};
        vt[8] = '{a: 8'h0F, b: 8'hF0, cin: 1'b0, s: 8'hFF, co: 1'b0};

        rst_n = 1'b0;
        sv8 = 0; a8 = 0; b8 = 0; cin8 = 0; rr8 = 0;
        sv16 = 0; a16 = 0; b16 = 0; cin16 = 0; rr16 = 0;

        #12;
        chk("rst_start_ready", 64'(sr8), 1);
        chk("rst_result_valid", 64'(rv8), 0);
        chk("rst_busy", 64'(busy8), 0);
        chk("rst_sum", 64'(s8), 0);
        chk("rst_cout", 64'(co8), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            start8(vt[i].a, vt[i].b, vt[i].cin);
            wait_rv8(lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 8);
            chk($sformatf("vec%0d_sum", i), 64'(s8), 64'(vt[i].s));
            chk($sformatf("vec%0d_cout", i), 64'(co8), 64'(vt[i].co));
            accept8();
            chk($sformatf("vec%0d_ready_after", i), 64'(sr8), 1);
            chk($sformatf("vec%0d_gated_sum", i), 64'(s8), 0);
        end

        // Back-pressure with foreign operands offered during RUN and DONE.
        start8(8'h12, 8'h34, 1'b1);
        sv8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        chk("bp_busy", 64'(busy8), 1);
        chk("bp_run_sum_gated", 64'(s8), 0);
        chk("bp_run_not_ready", 64'(sr8), 0);
        wait_rv8(lat);
        chk("bp_latency", 64'(lat), 8);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            chk("bp_hold_sum", 64'(s8), 64'h47);
            chk("bp_hold_cout", 64'(co8), 0);
            chk("bp_hold_valid", 64'(rv8), 1);
            chk("bp_hold_not_ready", 64'(sr8), 0);
        end
        sv8 = 1'b0;
        accept8();
        chk("bp_idle_ready", 64'(sr8), 1);
        chk("bp_idle_valid", 64'(rv8), 0);

        // Asynchronous reset in the middle of RUN.
        start8(8'hAA, 8'h55, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_busy", 64'(busy8), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(sr8), 1);
        chk("mid_rst_valid", 64'(rv8), 0);
        chk("mid_rst_busy", 64'(busy8), 0);
        chk("mid_rst_sum", 64'(s8), 0);
        chk("mid_rst_cout", 64'(co8), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        start8(8'h01, 8'h01, 1'b0);
        wait_rv8(lat);
        chk("post_rst_latency", 64'(lat), 8);
        chk("post_rst_sum", 64'(s8), 64'h02);
        chk("post_rst_cout", 64'(co8), 0);
        accept8();

        // Random regression on both widths in parallel.
        mon_en = 1'b1;
        rnd_en = 1'b1;
        fork
            drv8();
            drv16();
        join
        rnd_en = 1'b0;
        @(posedge clk); #2;
        rr8 = 1'b1;
        rr16 = 1'b1;
        for (int k = 0; k < 100 && (q8.size() != 0 || q16.size() != 0 || rv8 || rv16); k++)
            @(posedge clk);
        @(negedge clk); #1;
        chk("q8_drained", 64'(q8.size()), 0);
        chk("q16_drained", 64'(q16.size()), 0);
        chk("results8", 64'(got8), 1000);
        chk("results16", 64'(got16), 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around the team's half-adder cell: two half-adder stages plus an OR form a full adder, and a carry flip-flop closes the loop.
- Sits upstream of result consumers and downstream of an operand source. Operands are accepted through a valid/ready handshake, added LSB-first one bit per clock, and presented through a second valid/ready handshake.
- Used where area matters more than latency.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- START_VALID  input  1  operands and CIN valid
- START_READY  output  1  block can accept operands
- A_IN  input  WIDTH  operand A
- B_IN  input  WIDTH  operand B
- CIN  input  1  carry-in, sampled with operands
- RESULT_VALID  output  1  SUM_OUT/COUT hold a completed result
- RESULT_READY  input  1  consumer accepts result
- SUM_OUT  output  WIDTH  sum, (A_IN+B_IN+CIN) mod 2^WIDTH
- COUT  output  1  carry-out of MSB
- BUSY  output  1  addition in progress

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RST_N. All flops clear immediately on RST_N low, independent of CLK.
- Reset values: state=IDLE, counter=0, carry flop=0, operand/result shift registers=0. Outputs START_READY=1 after reset is released, RESULT_VALID=0, SUM_OUT=0, COUT=0, BUSY=0.
- States: IDLE, RUN, DONE.
- Combinational outputs:
  - START_READY = (state==IDLE).
  - BUSY = (state==RUN).
  - RESULT_VALID = (state==DONE).
- IDLE:
  - On an edge with START_VALID & START_READY: load A_IN and B_IN into shift registers, load CIN into the carry flop, clear the counter, go to RUN.
  - START_VALID without START_READY is ignored; no operands are captured in RUN or DONE.
- RUN: each edge processes one bit.
  - s = a0 ^ b0 ^ c.
  - c_next = (a0 & b0) | (c & (a0 ^ b0)), i.e. half adder, half adder, OR.
  - s shifts into the result register MSB-first, so after WIDTH shifts bit 0 is at LSB.
  - Operand registers shift right; the counter increments.
  - On the edge where counter==WIDTH-1: final bit processed, carry flop holds COUT, go to DONE.
- Latency: exactly WIDTH edges from the accepting edge to RESULT_VALID=1.
- DONE:
  - SUM_OUT and COUT present the result and stay stable until accepted.
  - On an edge with RESULT_VALID & RESULT_READY: go to IDLE; START_READY=1 the next cycle.
  - Minimum initiation interval is WIDTH+2 cycles with RESULT_READY held high.
- Output gating: SUM_OUT and COUT are forced to 0 whenever RESULT_VALID=0. Intermediate shift values are never visible.
- RESULT_READY outside DONE has no effect.
- Back-pressure: RESULT_READY low holds DONE indefinitely, with no change to outputs.
- Reset mid-operation (RUN or DONE): the in-flight result is discarded and the block returns to the reset values above. No partial result is ever flagged valid.
- Wrap-around: the sum is modulo 2^WIDTH; overflow is reported only through COUT.
- Counter width is clog2(WIDTH). No counter overflow is possible because the exit compare is at WIDTH-1.

Test Plan:
- Reset check: assert RST_N low mid-cycle, asynchronously → START_READY=1, RESULT_VALID=0, BUSY=0, SUM_OUT=0, COUT=0 without waiting for a clock edge.
- Basic add, WIDTH=8: A=0x35, B=0x1C, CIN=0 → RESULT_VALID rises exactly 8 edges after the accepting edge; SUM_OUT=0x51, COUT=0.
- Full ripple and overflow, WIDTH=8: A=0xFF, B=0x00, CIN=1 → SUM_OUT=0x00, COUT=1. Then A=0xFF, B=0xFF, CIN=1 → SUM_OUT=0xFF, COUT=1.
- Back-pressure and protocol:
  - Hold RESULT_READY=0 for 20 cycles after RESULT_VALID → outputs stable and START_READY=0 throughout.
  - Assert START_VALID with new operands during RUN/DONE → they are ignored.
  - Raise RESULT_READY → next cycle is IDLE.
- Reset mid-operation: apply RST_N low during RUN cycle 3 of A=0xAA, B=0x55 → all outputs return to reset values. A new transaction 0x01+0x01 then yields SUM_OUT=0x02, COUT=0.
- Random regression: 1000 random A/B/CIN at WIDTH=8 and WIDTH=16, with random RESULT_READY stalls → every result equals the golden {COUT,SUM_OUT}=A+B+CIN, latency is always WIDTH, and no results are lost or duplicated.
